// File: rtl/divisibility_by_n_serial.sv
// divisibility_by_n_serial
// Bit-serial remainder tracker for a constant divisor. An unsigned number
// arrives MSB-first in K-bit chunks; the running remainder, a divisible flag
// and a saturating bit count are kept per number. When the final chunk is
// accepted, a one-cycle res_valid pulse publishes the final remainder, and
// the running state restarts for the next number without an idle cycle.

module divisibility_by_n_serial #(
  parameter int DIVISOR = 5,
  parameter int K       = 1,
  parameter int CNT_W   = 16,
  localparam int REM_W  = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [K-1:0]     in_data,
  input  logic             in_last,
  output logic [REM_W-1:0] rem,
  output logic             divisible,
  output logic [CNT_W-1:0] nbits,
  output logic             res_valid,
  output logic [REM_W-1:0] res_rem,
  output logic             res_divisible
);

  // One extra bit holds 2r+b before the conditional subtract; because r is
  // always below DIVISOR, 2r+1 <= 2*DIVISOR-1 fits without truncation.
  localparam int EXT_W = REM_W + 1;
  localparam logic [EXT_W-1:0] DIV_EXT = EXT_W'(DIVISOR);

  // The counter sum is widened by four bits so that any K up to 8 is added
  // without overflow before the saturation compare.
  localparam int SUM_W = CNT_W + 4;
  localparam logic [SUM_W-1:0] K_EXT   = SUM_W'(K);
  localparam logic [SUM_W-1:0] CNT_TOP = {{4{1'b0}}, {CNT_W{1'b1}}};

  // Per-cycle operation selected from the control inputs. Reset is handled
  // ahead of this decode inside the register block.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_DATA  = 2'd1,
    OP_LAST  = 2'd2,
    OP_FLUSH = 2'd3
  } op_t;

  op_t              op_s;
  logic [REM_W-1:0] next_rem_s;
  logic             next_zero_s;
  logic [SUM_W-1:0] cnt_sum_s;
  logic [CNT_W-1:0] cnt_next_s;

  logic [REM_W-1:0] rem_r;
  logic             divisible_r;
  logic [CNT_W-1:0] nbits_r;
  logic             res_valid_r;
  logic [REM_W-1:0] res_rem_r;
  logic             res_divisible_r;

  // Single shift-and-reduce step: r = 2r + b, minus DIVISOR if that reached it.
  function automatic logic [REM_W-1:0] mod_step(
    input logic [REM_W-1:0] r,
    input logic             b
  );
    logic [EXT_W-1:0] t;
    t = {r, b};
    if (t >= DIV_EXT) begin
      t = t - DIV_EXT;
    end else begin
      t = t;
    end
    return t[REM_W-1:0];
  endfunction

  // Fold a whole K-bit chunk into the remainder, most significant bit first.
  function automatic logic [REM_W-1:0] mod_chunk(
    input logic [REM_W-1:0] r,
    input logic [K-1:0]     d
  );
    logic [REM_W-1:0] acc;
    acc = r;
    for (int i = K - 1; i >= 0; i--) begin
      acc = mod_step(acc, d[i]);
    end
    return acc;
  endfunction

  // Decode what this cycle does; clear outranks any data on the bus.
  always_comb begin
    op_s = OP_HOLD;
    if (clear) begin
      op_s = OP_FLUSH;
    end else if (in_valid && in_last) begin
      op_s = OP_LAST;
    end else if (in_valid) begin
      op_s = OP_DATA;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Remainder after folding in the presented chunk (only used when accepted).
  always_comb begin
    next_rem_s  = mod_chunk(rem_r, in_data);
    next_zero_s = (next_rem_s == {REM_W{1'b0}});
  end

  // Saturating bit count: sticks at all-ones rather than wrapping.
  always_comb begin
    cnt_sum_s  = {{4{1'b0}}, nbits_r} + K_EXT;
    cnt_next_s = nbits_r;
    if (cnt_sum_s > CNT_TOP) begin
      cnt_next_s = {CNT_W{1'b1}};
    end else begin
      cnt_next_s = cnt_sum_s[CNT_W-1:0];
    end
  end

  // Running state and result registers; every output comes from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r           <= {REM_W{1'b0}};
      divisible_r     <= 1'b1;
      nbits_r         <= {CNT_W{1'b0}};
      res_valid_r     <= 1'b0;
      res_rem_r       <= {REM_W{1'b0}};
      res_divisible_r <= 1'b1;
    end else begin
      case (op_s)
        OP_FLUSH: begin
          rem_r       <= {REM_W{1'b0}};
          divisible_r <= 1'b1;
          nbits_r     <= {CNT_W{1'b0}};
          res_valid_r <= 1'b0;
        end
        OP_LAST: begin
          res_valid_r     <= 1'b1;
          res_rem_r       <= next_rem_s;
          res_divisible_r <= next_zero_s;
          rem_r           <= {REM_W{1'b0}};
          divisible_r     <= 1'b1;
          nbits_r         <= {CNT_W{1'b0}};
        end
        OP_DATA: begin
          rem_r       <= next_rem_s;
          divisible_r <= next_zero_s;
          nbits_r     <= cnt_next_s;
          res_valid_r <= 1'b0;
        end
        OP_HOLD: begin
          res_valid_r <= 1'b0;
        end
        default: begin
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rem           = rem_r;
  assign divisible     = divisible_r;
  assign nbits         = nbits_r;
  assign res_valid     = res_valid_r;
  assign res_rem       = res_rem_r;
  assign res_divisible = res_divisible_r;

endmodule

// File: tb/tb_divisibility_by_n_serial.sv
// Bench for divisibility_by_n_serial. Several divisor/chunk-width variants
// share one stimulus stream (each takes the low K bits of an 8-bit bus).
// An arithmetic model (value mod D) predicts every output of every variant
// each cycle; directed literal checks pin the model on the hand-worked cases.

module tb_divisibility_by_n_serial;

  localparam int NI = 7;
  localparam int DV [NI] = '{5, 7, 3, 13, 65535, 8, 2};
  localparam int KV [NI] = '{1, 4, 1, 3, 8, 3, 1};
  localparam int CV [NI] = '{4, 16, 16, 16, 16, 16, 16};

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       in_last;
  logic [7:0] data8;

  logic [31:0] d_rem [NI];
  logic [31:0] d_nb  [NI];
  logic [31:0] d_rr  [NI];
  logic        d_div [NI];
  logic        d_rv  [NI];
  logic        d_rd  [NI];

  longint m_rem [NI];
  longint m_nb  [NI];
  longint m_rr  [NI];
  bit     m_rv  [NI];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int RW = (DV[g] > 2) ? $clog2(DV[g]) : 1;
    logic [RW-1:0]    rem_w;
    logic [RW-1:0]    rr_w;
    logic [CV[g]-1:0] nb_w;
    logic             div_w;
    logic             rv_w;
    logic             rd_w;

    divisibility_by_n_serial #(
      .DIVISOR(DV[g]),
      .K      (KV[g]),
      .CNT_W  (CV[g])
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .in_valid     (in_valid),
      .in_data      (data8[KV[g]-1:0]),
      .in_last      (in_last),
      .rem          (rem_w),
      .divisible    (div_w),
      .nbits        (nb_w),
      .res_valid    (rv_w),
      .res_rem      (rr_w),
      .res_divisible(rd_w)
    );

    assign d_rem[g] = 32'(rem_w);
    assign d_rr[g]  = 32'(rr_w);
    assign d_nb[g]  = 32'(nb_w);
    assign d_div[g] = div_w;
    assign d_rv[g]  = rv_w;
    assign d_rd[g]  = rd_w;
  end

  function automatic longint mnext(int i, longint r, logic [7:0] d);
    longint mask;
    mask = (longint'(1) << KV[i]) - 1;
    return (r * (longint'(1) << KV[i]) + (longint'(d) & mask)) % DV[i];
  endfunction

  function automatic longint cmax(int i);
    return (longint'(1) << CV[i]) - 1;
  endfunction

  task automatic check(input string nm, input int i, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, i, $time, act, exp);
    end
  endtask

  // Reference model: the number so far, reduced mod D after every chunk.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_rem[i] <= 0;
        m_nb[i]  <= 0;
        m_rr[i]  <= 0;
        m_rv[i]  <= 1'b0;
      end else if (clear) begin
        m_rem[i] <= 0;
        m_nb[i]  <= 0;
        m_rv[i]  <= 1'b0;
      end else if (in_valid && in_last) begin
        m_rr[i]  <= mnext(i, m_rem[i], data8);
        m_rv[i]  <= 1'b1;
        m_rem[i] <= 0;
        m_nb[i]  <= 0;
      end else if (in_valid) begin
        m_rem[i] <= mnext(i, m_rem[i], data8);
        m_nb[i]  <= (m_nb[i] + KV[i] > cmax(i)) ? cmax(i) : m_nb[i] + KV[i];
        m_rv[i]  <= 1'b0;
      end else begin
        m_rv[i]  <= 1'b0;
      end
    end
  end

  // Compare every output of every variant against the model each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check("rem",           i, longint'(d_rem[i]), m_rem[i]);
        check("divisible",     i, longint'(d_div[i]), longint'(m_rem[i] == 0));
        check("nbits",         i, longint'(d_nb[i]),  m_nb[i]);
        check("res_valid",     i, longint'(d_rv[i]),  longint'(m_rv[i]));
        check("res_rem",       i, longint'(d_rr[i]),  m_rr[i]);
        check("res_divisible", i, longint'(d_rd[i]),  longint'(m_rr[i] == 0));
      end
    end
  end

  task automatic step(input logic v, input logic l, input logic [7:0] d, input logic c);
    in_valid = v;
    in_last  = l;
    data8    = d;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp2 [3];
    int len;
    rst      = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    data8    = 8'h00;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rem",       0, longint'(d_rem[0]), 0);
    check("rst_divisible", 0, longint'(d_div[0]), 1);
    check("rst_nbits",     0, longint'(d_nb[0]),  0);
    check("rst_res_valid", 0, longint'(d_rv[0]),  0);
    check("rst_res_rem",   0, longint'(d_rr[0]),  0);
    check("rst_res_div",   0, longint'(d_rd[0]),  1);
    rst = 1'b0;

    // D=5,K=1: 1010 = 10 -> divisible, one pulse
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    check("t1_res_valid", 0, longint'(d_rv[0]), 1);
    check("t1_res_rem",   0, longint'(d_rr[0]), 0);
    check("t1_res_div",   0, longint'(d_rd[0]), 1);
    check("t1_nbits",     0, longint'(d_nb[0]), 0);
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    check("t1_pulse_once", 0, longint'(d_rv[0]), 0);

    // D=5,K=1: 1011 = 11 -> running 1,2,0 then result 1
    exp2 = '{1, 2, 0};
    step(1'b1, 1'b0, 8'h01, 1'b0);
    check("t2_rem0", 0, longint'(d_rem[0]), exp2[0]);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("t2_rem1", 0, longint'(d_rem[0]), exp2[1]);
    step(1'b1, 1'b0, 8'h01, 1'b0);
    check("t2_rem2", 0, longint'(d_rem[0]), exp2[2]);
    step(1'b1, 1'b1, 8'h01, 1'b0);
    check("t2_res_rem", 0, longint'(d_rr[0]), 1);
    check("t2_res_div", 0, longint'(d_rd[0]), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // D=7,K=4: 0xFF = 255 -> 3, then 0x7 -> 0 on the very next cycle
    step(1'b1, 1'b0, 8'h0F, 1'b0);
    check("t3_rem",   1, longint'(d_rem[1]), 1);
    check("t3_nbits", 1, longint'(d_nb[1]),  4);
    step(1'b1, 1'b1, 8'h0F, 1'b0);
    check("t3_rv_a",  1, longint'(d_rv[1]), 1);
    check("t3_rr_a",  1, longint'(d_rr[1]), 3);
    check("t3_nb_a",  1, longint'(d_nb[1]), 0);
    step(1'b1, 1'b1, 8'h07, 1'b0);
    check("t3_rv_b",  1, longint'(d_rv[1]), 1);
    check("t3_rr_b",  1, longint'(d_rr[1]), 0);
    check("t3_rd_b",  1, longint'(d_rd[1]), 1);
    check("t3_nb_b",  1, longint'(d_nb[1]), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // D=3,K=1: 10 -> 2; then 110, clear; then 11 -> 0
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    check("t4_rr_pre", 2, longint'(d_rr[2]), 2);
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("t4_nbits_pre", 2, longint'(d_nb[2]), 3);
    step(1'b1, 1'b1, 8'h01, 1'b1);
    check("t4_clr_rem",   2, longint'(d_rem[2]), 0);
    check("t4_clr_nbits", 2, longint'(d_nb[2]),  0);
    check("t4_clr_rv",    2, longint'(d_rv[2]),  0);
    check("t4_clr_rr",    2, longint'(d_rr[2]),  2);
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b1, 8'h01, 1'b0);
    check("t4_rv", 2, longint'(d_rv[2]), 1);
    check("t4_rr", 2, longint'(d_rr[2]), 0);
    check("t4_rd", 2, longint'(d_rd[2]), 1);

    // D=5,K=1,CNT_W=4: 20 ones -> nbits 15, rem 0; one more -> rem 1; rst mid-number
    for (int b = 0; b < 20; b++) step(1'b1, 1'b0, 8'hFF, 1'b0);
    check("t5_nbits_sat", 0, longint'(d_nb[0]),  15);
    check("t5_rem",       0, longint'(d_rem[0]), 0);
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    check("t5_rem_more",  0, longint'(d_rem[0]), 1);
    check("t5_nbits_hold",0, longint'(d_nb[0]),  15);
    rst = 1'b1;
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    rst = 1'b0;
    check("t5_rst_rem",   0, longint'(d_rem[0]), 0);
    check("t5_rst_div",   0, longint'(d_div[0]), 1);
    check("t5_rst_nbits", 0, longint'(d_nb[0]),  0);
    check("t5_rst_rv",    0, longint'(d_rv[0]),  0);
    check("t5_rst_rr",    0, longint'(d_rr[0]),  0);
    check("t5_rst_rd",    0, longint'(d_rd[0]),  1);

    // Random numbers with idle gaps, garbage on idle cycles and rare clears
    for (int n = 0; n < 1000; n++) begin
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0)
          step(1'b0, 1'($urandom), 8'($urandom), 1'b0);
        step(1'b1, (c == len - 1), 8'($urandom), ($urandom_range(0, 199) == 0));
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
